// File: rtl/indec_ms_pkg.sv
// logIP_pkg: opcodes, framing states and stage-field helpers shared by the SUMP command decoder
package logIP_pkg;
  typedef enum logic {IDLE, ARG} state_t;
  localparam logic [7:0] OP_RST  = 8'h00;
  localparam logic [7:0] OP_ARM  = 8'h01;
  localparam logic [7:0] OP_ID   = 8'h02;
  localparam logic [7:0] OP_META = 8'h04;
  localparam logic [7:0] OP_XON  = 8'h11;
  localparam logic [7:0] OP_XOFF = 8'h13;
  localparam logic [7:0] OP_DIV  = 8'h80;
  localparam logic [7:0] OP_CNT  = 8'h81;
  localparam logic [7:0] OP_FLGS = 8'h82;
  localparam logic [7:0] OP_MASK = 8'hC0;
  localparam logic [7:0] OP_VAL  = 8'hC1;
  localparam logic [7:0] OP_CFG  = 8'hC2;
  localparam logic [7:0] STG_MASK = 8'h0C;
  // stage opcode once the stage field is cleared: 11_00_xx_ss with ss in 0..2
  function automatic logic is_stage(input logic [7:0] op);
    return (op & ~STG_MASK) inside {OP_MASK, OP_VAL, OP_CFG};
  endfunction
endpackage

// File: rtl/indec_ms_if.sv
// indec_ms_if: received byte stream in, decoded command strobes and argument out
interface indec_ms_if #(parameter int STAGES = 4);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  logic rx_stb_i;
  logic [7:0] rx_data_i;
  logic [31:0] cmd_o;
  logic [SW-1:0] stg_o;
  logic stb_o, sft_rst_o, armd_o, id_o, meta_o, xon_o, xoff_o;
  logic set_mask_o, set_val_o, set_cfg_o, set_div_o, set_cnt_o, set_flgs_o;
  logic err_o, busy_o;
  modport master (
    output rx_stb_i, rx_data_i,
    input cmd_o, stg_o, stb_o, sft_rst_o, armd_o, id_o, meta_o, xon_o, xoff_o,
    input set_mask_o, set_val_o, set_cfg_o, set_div_o, set_cnt_o, set_flgs_o, err_o, busy_o
  );
  modport slave (
    input rx_stb_i, rx_data_i,
    output cmd_o, stg_o, stb_o, sft_rst_o, armd_o, id_o, meta_o, xon_o, xoff_o,
    output set_mask_o, set_val_o, set_cfg_o, set_div_o, set_cnt_o, set_flgs_o, err_o, busy_o
  );
endinterface

// File: rtl/indec_ms_cmd_asm.sv
// cmd_asm: frames the byte stream into short and 5-byte long commands with an inter-byte timeout
module cmd_asm
  import logIP_pkg::*;
#(
  parameter int TMO_CYC = 100000
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic stb,
  input  logic [7:0] data,
  output logic [7:0] opc,
  output logic [31:0] arg,
  output logic sht,
  output logic lng,
  output logic tmo,
  output logic busy
);
  localparam int TW = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TMO_CYC - 1);
  state_t st;
  logic [1:0] cnt;
  logic [TW-1:0] tmr;
  logic [7:0] op_q;
  logic [23:0] arg_q;
  assign busy = st == ARG;
  assign sht = !busy && stb && !data[7];
  assign lng = busy && stb && cnt == 2'd3;
  assign tmo = busy && !stb && tmr == TMAX;
  assign opc = busy ? op_q : data;
  assign arg = {data, arg_q};
  // framing: opcode capture in IDLE, argument shift and timeout in ARG; a byte beats expiry
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      st <= IDLE;
      cnt <= '0;
      tmr <= '0;
      op_q <= '0;
      arg_q <= '0;
    end else if (!busy) begin
      if (stb && data[7]) begin
        st <= ARG;
        op_q <= data;
        cnt <= '0;
        tmr <= '0;
      end
    end else if (stb) begin
      arg_q <= {data, arg_q[23:8]};
      cnt <= cnt + 2'd1;
      tmr <= '0;
      if (cnt == 2'd3) st <= IDLE;
    end else if (tmr == TMAX) begin
      st <= IDLE;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end
endmodule

// File: rtl/indec_ms.sv
// indec_ms: SUMP command decoder with parametrised trigger stages and registered decode strobes
module indec_ms
  import logIP_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int TMO_CYC = 100000
) (
  input  logic clk_i,
  input  logic rst_in,
  indec_ms_if.slave bus
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  logic [7:0] opc;
  logic [31:0] arg;
  logic sht, lng, tmo, busy;
  logic s_ok, stg_ok, l_ok;
  cmd_asm #(.TMO_CYC(TMO_CYC)) u_asm (
    .clk_i(clk_i),
    .rst_in(rst_in),
    .stb(bus.rx_stb_i),
    .data(bus.rx_data_i),
    .opc(opc),
    .arg(arg),
    .sht(sht),
    .lng(lng),
    .tmo(tmo),
    .busy(busy)
  );
  assign bus.busy_o = busy;
  // opcode classification for the byte or frame completing this cycle
  always_comb begin
    s_ok = opc inside {OP_RST, OP_ARM, OP_ID, OP_META, OP_XON, OP_XOFF};
    stg_ok = is_stage(opc) && int'(opc[3:2]) < STAGES;
    l_ok = stg_ok || opc inside {OP_DIV, OP_CNT, OP_FLGS};
  end
  // registered one-cycle strobes; argument and stage only move on an accepted long command
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      bus.cmd_o <= '0;
      bus.stg_o <= '0;
      bus.stb_o <= 1'b0;
      bus.err_o <= 1'b0;
      bus.sft_rst_o <= 1'b0;
      bus.armd_o <= 1'b0;
      bus.id_o <= 1'b0;
      bus.meta_o <= 1'b0;
      bus.xon_o <= 1'b0;
      bus.xoff_o <= 1'b0;
      bus.set_mask_o <= 1'b0;
      bus.set_val_o <= 1'b0;
      bus.set_cfg_o <= 1'b0;
      bus.set_div_o <= 1'b0;
      bus.set_cnt_o <= 1'b0;
      bus.set_flgs_o <= 1'b0;
    end else begin
      bus.sft_rst_o <= sht && opc == OP_RST;
      bus.armd_o <= sht && opc == OP_ARM;
      bus.id_o <= sht && opc == OP_ID;
      bus.meta_o <= sht && opc == OP_META;
      bus.xon_o <= sht && opc == OP_XON;
      bus.xoff_o <= sht && opc == OP_XOFF;
      bus.set_mask_o <= lng && stg_ok && opc[1:0] == 2'd0;
      bus.set_val_o <= lng && stg_ok && opc[1:0] == 2'd1;
      bus.set_cfg_o <= lng && stg_ok && opc[1:0] == 2'd2;
      bus.set_div_o <= lng && opc == OP_DIV;
      bus.set_cnt_o <= lng && opc == OP_CNT;
      bus.set_flgs_o <= lng && opc == OP_FLGS;
      bus.stb_o <= (sht && s_ok) || (lng && l_ok);
      bus.err_o <= (sht && !s_ok) || (lng && !l_ok) || tmo;
      if (lng && l_ok) bus.cmd_o <= arg;
      if (lng && stg_ok) bus.stg_o <= SW'(opc[3:2]);
    end
  end
endmodule

// File: doc/indec_ms.md
# indec_ms

Parametrised multi-stage command decoder for the SUMP command path: consumes the raw byte stream from the UART receiver, assembles short (1-byte) and long (5-byte) commands, and emits single-cycle decode strobes with the 32-bit argument to the capture, trigger and flow-control logic. It generalises the fixed four-stage decoder: trigger stage count is a parameter, bytes are framed internally with an inter-byte timeout, and unknown or out-of-range commands are reported instead of silently dropped.

## Interface
- STAGES, 4: number of trigger stages, legal range 1..4; stage index width SW = max(1, $clog2(STAGES)).
- TMO_CYC, 100000: clock cycles allowed between bytes of one long command; must be ≥ 2.
- clk_i  in  1  system clock.
- rst_in  in  1  reset; one clock, reset synchronous and active-low.
- rx_stb_i  in  1  byte valid, one-cycle pulse per byte.
- rx_data_i  in  8  received byte.
- cmd_o  out  32  assembled argument, LSB byte received first; held until next long command.
- stg_o  out  SW  trigger stage of last stage command.
- stb_o  out  1  pulse: any valid command decoded.
- sft_rst_o, armd_o, id_o, meta_o, xon_o, xoff_o  out  1 each  short-command pulses (0x00, 0x01, 0x02, 0x04, 0x11, 0x13).
- set_mask_o, set_val_o, set_cfg_o  out  1 each  stage commands 0xC0/0xC1/0xC2 | (stage<<2).
- set_div_o, set_cnt_o, set_flgs_o  out  1 each  long commands 0x80/0x81/0x82.
- err_o  out  1  pulse: unknown opcode, stage ≥ STAGES, or timeout.
- busy_o  out  1  long command partially received.

## Operation
- States: IDLE, ARG (collecting 4 argument bytes, byte counter 0..3).
- IDLE, byte with bit 7 = 0: decode as short command next cycle; known opcode → its pulse + stb_o; unknown → err_o only. State stays IDLE.
- IDLE, byte with bit 7 = 1: latch opcode, clear counter and timeout, go ARG; busy_o = 1.
- ARG: every byte is data (including 0x00 and 0x11/0x13), shifted into argument register at position counter*8. On the 4th byte: decode latched opcode, load cmd_o, return IDLE.
- Long decode: bits [7:6] = 2'b11 and bits [1:0] ∈ {0,1,2} → stage command, stage = opcode[3:2]; stage ≥ STAGES or bits [1:0] = 3 or bits [5:4] ≠ 0 → err_o, no stb_o, cmd_o and stg_o unchanged. 0x80/0x81/0x82 → respective pulse. Any other → err_o.
- Timeout: in ARG the counter increments each cycle without rx_stb_i; reaching TMO_CYC → err_o, discard partial argument, IDLE. Counter clears on each accepted byte.
- At most one decode pulse and stb_o per command; all pulses one cycle wide; err_o and stb_o never asserted together.
- sft_rst_o is only a pulse; the block does not reset itself on it.

## Timing
- Reset: state IDLE, counters 0, cmd_o = 0, stg_o = 0, every pulse output 0, busy_o = 0.
- Short command latency: pulse in the cycle after rx_stb_i of the opcode byte.
- Long command latency: pulses, cmd_o and stg_o update in the cycle after rx_stb_i of the 4th argument byte.
- Back-to-back bytes on consecutive cycles accepted without loss.
- Timeout expiry and rx_stb_i in the same cycle: byte wins, timeout cleared, no err_o.
- Reset mid-ARG: partial command discarded, no pulses in the reset cycle or the cycle after.
- Outputs are all registered; no combinational path from rx_* to outputs.

## Structure
- Shared package logIP_pkg: opcode localparams (short, long, stage base codes), state enum typedef, stage-field mask.
- One sub-module cmd_asm: IDLE/ARG framing FSM, byte counter, timeout counter, argument shift register; outputs opcode, argument, frame-done, timeout pulses. indec_ms wraps it with the registered decode.

## Test plan
- Bytes 0x01, then 0x02 on consecutive cycles → armd_o then id_o, each one cycle, with stb_o, latency 1.
- 0xC4, 0x78, 0x56, 0x34, 0x12 with STAGES = 4 → set_mask_o, stg_o = 1, cmd_o = 0x12345678.
- STAGES = 2, 0xCD + 4 bytes → err_o once, no stb_o, stg_o/cmd_o unchanged; busy_o low afterwards.
- 0x81, 0x00, 0x11 then idle TMO_CYC cycles → no xon_o, err_o at expiry, IDLE; following 0x13 → xoff_o.
- 0x80 + 3 bytes, 4th byte in the exact expiry cycle → set_div_o, no err_o.
- Reset asserted after 2 argument bytes, then 0x00 → only sft_rst_o, all other outputs 0.
